// File: rtl/decode_stage.sv
// RV32I instruction decode stage: decodes the IF/ID instruction into the ID/EX register,
// with writeback bypass, load-use bubble insertion and redirect flush.
module decode_stage #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_instr_i,
    input  logic        flush_i,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    input  logic [31:0] rf_rs1_data_i,
    input  logic [31:0] rf_rs2_data_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_data_i,
    output logic        stall_if_o,
    output logic        ex_valid_o,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_rs1_data_o,
    output logic [31:0] ex_rs2_data_o,
    output logic [31:0] ex_imm_o,
    output logic [4:0]  ex_rs1_o,
    output logic [4:0]  ex_rs2_o,
    output logic [4:0]  ex_rd_o,
    output logic [2:0]  ex_funct3_o,
    output logic [3:0]  ex_alu_op_o,
    output logic        ex_reg_we_o,
    output logic        ex_is_load_o,
    output logic        ex_is_store_o,
    output logic        ex_is_branch_o,
    output logic        ex_is_jal_o,
    output logic        ex_is_jalr_o,
    output logic        ex_alu_src_imm_o,
    output logic        ex_is_lui_o,
    output logic        ex_is_auipc_o,
    output logic        ex_illegal_o
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluSll   = 4'd2;
    localparam logic [3:0] AluSlt   = 4'd3;
    localparam logic [3:0] AluSltu  = 4'd4;
    localparam logic [3:0] AluXor   = 4'd5;
    localparam logic [3:0] AluSrl   = 4'd6;
    localparam logic [3:0] AluSra   = 4'd7;
    localparam logic [3:0] AluOr    = 4'd8;
    localparam logic [3:0] AluAnd   = 4'd9;
    localparam logic [3:0] AluPassB = 4'd10;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic        reg_we;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        alu_src_imm;
        logic        is_lui;
        logic        is_auipc;
        logic        illegal;
    } id_ex_t;

    id_ex_t ex_q, ex_d;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = if_instr_i[6:0];
    assign rd     = if_instr_i[11:7];
    assign funct3 = if_instr_i[14:12];
    assign rs1    = if_instr_i[19:15];
    assign rs2    = if_instr_i[24:20];
    assign funct7 = if_instr_i[31:25];

    assign imm_i  = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
    assign imm_s  = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
    assign imm_b  = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7], if_instr_i[30:25],
                     if_instr_i[11:8], 1'b0};
    assign imm_u  = {if_instr_i[31:12], 12'b0};
    assign imm_j  = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12], if_instr_i[20],
                     if_instr_i[30:21], 1'b0};
    assign imm_sh = {27'b0, if_instr_i[24:20]};

    assign rf_rs1_o = rs1;
    assign rf_rs2_o = rs2;

    logic [31:0] dec_imm;
    logic [3:0]  dec_alu_op, f3_alu_op;
    logic        dec_legal, dec_writes_rd, dec_src_imm;
    logic        dec_load, dec_store, dec_branch, dec_jal, dec_jalr, dec_lui, dec_auipc;

    // Shared funct3 -> ALU op mapping for OP and OP-IMM; SUB/SRA selected by funct7[5].
    always_comb begin
        f3_alu_op = AluAdd;
        unique case (funct3)
            3'd0: f3_alu_op = (opcode == OpReg && funct7[5]) ? AluSub : AluAdd;
            3'd1: f3_alu_op = AluSll;
            3'd2: f3_alu_op = AluSlt;
            3'd3: f3_alu_op = AluSltu;
            3'd4: f3_alu_op = AluXor;
            3'd5: f3_alu_op = funct7[5] ? AluSra : AluSrl;
            3'd6: f3_alu_op = AluOr;
            3'd7: f3_alu_op = AluAnd;
        endcase
    end

    always_comb begin
        dec_imm       = imm_i;
        dec_alu_op    = AluAdd;
        dec_legal     = 1'b1;
        dec_writes_rd = 1'b0;
        dec_src_imm   = 1'b0;
        dec_load      = 1'b0;
        dec_store     = 1'b0;
        dec_branch    = 1'b0;
        dec_jal       = 1'b0;
        dec_jalr      = 1'b0;
        dec_lui       = 1'b0;
        dec_auipc     = 1'b0;
        case (opcode)
            OpLui: begin
                dec_imm = imm_u; dec_alu_op = AluPassB; dec_src_imm = 1'b1;
                dec_lui = 1'b1;  dec_writes_rd = 1'b1;
            end
            OpAuipc: begin
                dec_imm = imm_u; dec_src_imm = 1'b1; dec_auipc = 1'b1; dec_writes_rd = 1'b1;
            end
            OpJal: begin
                dec_imm = imm_j; dec_src_imm = 1'b1; dec_jal = 1'b1; dec_writes_rd = 1'b1;
            end
            OpJalr: begin
                dec_src_imm = 1'b1; dec_jalr = 1'b1; dec_writes_rd = 1'b1;
                dec_legal   = (funct3 == 3'd0);
            end
            OpBranch: begin
                dec_imm    = imm_b;
                dec_branch = 1'b1;
                dec_legal  = (funct3 != 3'd2) && (funct3 != 3'd3);
                dec_alu_op = funct3[2] ? (funct3[1] ? AluSltu : AluSlt) : AluSub;
            end
            OpLoad: begin
                dec_src_imm = 1'b1; dec_load = 1'b1; dec_writes_rd = 1'b1;
                dec_legal   = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            end
            OpStore: begin
                dec_imm = imm_s; dec_src_imm = 1'b1; dec_store = 1'b1;
                dec_legal = (funct3 < 3'd3);
            end
            OpImm: begin
                dec_src_imm   = 1'b1;
                dec_writes_rd = 1'b1;
                dec_alu_op    = f3_alu_op;
                if (funct3 == 3'd1) begin
                    dec_imm   = imm_sh;
                    dec_legal = (funct7 == 7'h00);
                end else if (funct3 == 3'd5) begin
                    dec_imm   = imm_sh;
                    dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                end
            end
            OpReg: begin
                dec_writes_rd = 1'b1;
                dec_alu_op    = f3_alu_op;
                dec_legal     = (funct7 == 7'h00) ||
                                (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
            end
            OpFence, OpSystem: ;
            default: dec_legal = 1'b0;
        endcase
    end

    logic uses_rs1, uses_rs2, hazard;
    logic [31:0] rs1_data, rs2_data;

    assign uses_rs1 = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
    assign uses_rs2 = (opcode == OpReg) || (opcode == OpStore) || (opcode == OpBranch);
    assign hazard   = if_valid_i && ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                      ((uses_rs1 && ex_q.rd == rs1) || (uses_rs2 && ex_q.rd == rs2));
    assign stall_if_o = hazard && !flush_i && !rst_i;

    // Write-through bypass: WB writes the RF this same cycle, so forward its data.
    assign rs1_data = (BYPASS_EN && wb_we_i && wb_rd_i != 5'd0 && wb_rd_i == rs1) ?
                      wb_data_i : rf_rs1_data_i;
    assign rs2_data = (BYPASS_EN && wb_we_i && wb_rd_i != 5'd0 && wb_rd_i == rs2) ?
                      wb_data_i : rf_rs2_data_i;

    always_comb begin
        ex_d = '0;
        if (!flush_i && !hazard) begin
            ex_d.valid    = if_valid_i;
            ex_d.pc       = if_pc_i;
            ex_d.rs1_data = rs1_data;
            ex_d.rs2_data = rs2_data;
            ex_d.imm      = dec_imm;
            ex_d.rs1      = rs1;
            ex_d.rs2      = rs2;
            ex_d.rd       = rd;
            ex_d.funct3   = funct3;
            if (if_valid_i && !dec_legal) begin
                ex_d.illegal = 1'b1;
            end else if (if_valid_i) begin
                ex_d.alu_op      = dec_alu_op;
                ex_d.reg_we      = dec_writes_rd && (rd != 5'd0);
                ex_d.is_load     = dec_load;
                ex_d.is_store    = dec_store;
                ex_d.is_branch   = dec_branch;
                ex_d.is_jal      = dec_jal;
                ex_d.is_jalr     = dec_jalr;
                ex_d.alu_src_imm = dec_src_imm;
                ex_d.is_lui      = dec_lui;
                ex_d.is_auipc    = dec_auipc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid_o       = ex_q.valid;
    assign ex_pc_o          = ex_q.pc;
    assign ex_rs1_data_o    = ex_q.rs1_data;
    assign ex_rs2_data_o    = ex_q.rs2_data;
    assign ex_imm_o         = ex_q.imm;
    assign ex_rs1_o         = ex_q.rs1;
    assign ex_rs2_o         = ex_q.rs2;
    assign ex_rd_o          = ex_q.rd;
    assign ex_funct3_o      = ex_q.funct3;
    assign ex_alu_op_o      = ex_q.alu_op;
    assign ex_reg_we_o      = ex_q.reg_we;
    assign ex_is_load_o     = ex_q.is_load;
    assign ex_is_store_o    = ex_q.is_store;
    assign ex_is_branch_o   = ex_q.is_branch;
    assign ex_is_jal_o      = ex_q.is_jal;
    assign ex_is_jalr_o     = ex_q.is_jalr;
    assign ex_alu_src_imm_o = ex_q.alu_src_imm;
    assign ex_is_lui_o      = ex_q.is_lui;
    assign ex_is_auipc_o    = ex_q.is_auipc;
    assign ex_illegal_o     = ex_q.illegal;

endmodule
